// File: rtl/fetch_stage.sv
// fetch_stage: drives the PC onto the instruction-memory bus and assembles
// one- or two-word instructions. A two-word instruction is a 16-bit opcode
// followed by a 16-bit immediate. The stage computes the sequential next PC
// and holds the IF/ID pipeline register, with stall and flush control.
module fetch_stage #(
   parameter int          IMM_FLAG_BIT = 0,
   parameter logic [15:0] NOP_WORD     = 16'h0000
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        Stall,
   input  logic        Flush,
   input  logic [31:0] PC,
   output logic [31:0] InstrMemAddr,
   input  logic [15:0] InstrMemData,
   output logic [31:0] NextPC,
   output logic [15:0] IFID_Instr,
   output logic [15:0] IFID_Imm,
   output logic        IFID_HasImm,
   output logic [31:0] IFID_PC,
   output logic [31:0] IFID_PCNext,
   output logic        IFID_Valid
);

   typedef enum logic {
      S_OP  = 1'b0,
      S_IMM = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] op_word_q, op_word_d;
   logic [31:0] op_pc_q, op_pc_d;
   logic [15:0] ifid_instr_q, ifid_instr_d;
   logic [15:0] ifid_imm_q, ifid_imm_d;
   logic        ifid_has_imm_q, ifid_has_imm_d;
   logic [31:0] ifid_pc_q, ifid_pc_d;
   logic [31:0] ifid_pc_next_q, ifid_pc_next_d;
   logic        ifid_valid_q, ifid_valid_d;

   logic [31:0] pc_plus_one_s;
   logic        imm_flag_s;
   logic        hold_pc_s;

   // The PC wraps modulo 2^32.
   assign pc_plus_one_s = PC + 32'd1;
   assign imm_flag_s    = InstrMemData[IMM_FLAG_BIT];

   // Only a plain stall freezes the PC. Reset and flush always let it advance,
   // and the PC register's redirect path overrides it when needed.
   assign hold_pc_s     = Stall & ~Flush & ~Rst;

   assign InstrMemAddr  = PC;
   assign NextPC        = hold_pc_s ? PC : pc_plus_one_s;

   // Next-state logic for the opcode/immediate FSM and the IF/ID register.
   always_comb begin
      state_d        = state_q;
      op_word_d      = op_word_q;
      op_pc_d        = op_pc_q;
      ifid_instr_d   = ifid_instr_q;
      ifid_imm_d     = ifid_imm_q;
      ifid_has_imm_d = ifid_has_imm_q;
      ifid_pc_d      = ifid_pc_q;
      ifid_pc_next_d = ifid_pc_next_q;
      ifid_valid_d   = ifid_valid_q;
      if (Flush) begin
         // Kill whatever is in flight, including a half-fetched opcode.
         state_d        = S_OP;
         op_word_d      = NOP_WORD;
         op_pc_d        = 32'd0;
         ifid_instr_d   = NOP_WORD;
         ifid_imm_d     = NOP_WORD;
         ifid_has_imm_d = 1'b0;
         ifid_pc_d      = 32'd0;
         ifid_pc_next_d = 32'd0;
         ifid_valid_d   = 1'b0;
      end else if (Stall) begin
         state_d = state_q;
      end else begin
         case (state_q)
            S_OP: begin
               if (imm_flag_s) begin
                  // Park the opcode and emit a bubble while the immediate is fetched.
                  op_word_d    = InstrMemData;
                  op_pc_d      = PC;
                  ifid_valid_d = 1'b0;
                  state_d      = S_IMM;
               end else begin
                  ifid_instr_d   = InstrMemData;
                  ifid_imm_d     = NOP_WORD;
                  ifid_has_imm_d = 1'b0;
                  ifid_pc_d      = PC;
                  ifid_pc_next_d = pc_plus_one_s;
                  ifid_valid_d   = 1'b1;
                  state_d        = S_OP;
               end
            end
            S_IMM: begin
               // The immediate word is taken verbatim. It is never flag-decoded.
               ifid_instr_d   = op_word_q;
               ifid_imm_d     = InstrMemData;
               ifid_has_imm_d = 1'b1;
               ifid_pc_d      = op_pc_q;
               ifid_pc_next_d = pc_plus_one_s;
               ifid_valid_d   = 1'b1;
               state_d        = S_OP;
            end
            default: begin
               state_d      = S_OP;
               ifid_valid_d = 1'b0;
            end
         endcase
      end
   end

   // State and IF/ID register, with a synchronous reset that takes priority.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q        <= S_OP;
         op_word_q      <= NOP_WORD;
         op_pc_q        <= 32'd0;
         ifid_instr_q   <= NOP_WORD;
         ifid_imm_q     <= NOP_WORD;
         ifid_has_imm_q <= 1'b0;
         ifid_pc_q      <= 32'd0;
         ifid_pc_next_q <= 32'd0;
         ifid_valid_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         op_word_q      <= op_word_d;
         op_pc_q        <= op_pc_d;
         ifid_instr_q   <= ifid_instr_d;
         ifid_imm_q     <= ifid_imm_d;
         ifid_has_imm_q <= ifid_has_imm_d;
         ifid_pc_q      <= ifid_pc_d;
         ifid_pc_next_q <= ifid_pc_next_d;
         ifid_valid_q   <= ifid_valid_d;
      end
   end

   assign IFID_Instr  = ifid_instr_q;
   assign IFID_Imm    = ifid_imm_q;
   assign IFID_HasImm = ifid_has_imm_q;
   assign IFID_PC     = ifid_pc_q;
   assign IFID_PCNext = ifid_pc_next_q;
   assign IFID_Valid  = ifid_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vectors with literal expectations, plus an
// instruction-level reference model that is checked on every falling edge.
module tb_fetch_stage;

   logic        Clk;
   logic        Rst;
   logic        Stall;
   logic        Flush;
   logic [31:0] PC;
   logic [31:0] InstrMemAddr;
   logic [15:0] InstrMemData;
   logic [31:0] NextPC;
   logic [15:0] IFID_Instr;
   logic [15:0] IFID_Imm;
   logic        IFID_HasImm;
   logic [31:0] IFID_PC;
   logic [31:0] IFID_PCNext;
   logic        IFID_Valid;

   int checks = 0;
   int errors = 0;

   // Reference model: the architecturally visible IF/ID contents, plus a
   // record of any opcode that is still waiting for its immediate.
   bit          model_on = 1'b0;
   bit          m_waiting;
   logic [15:0] m_wait_op;
   logic [31:0] m_wait_pc;
   logic [15:0] m_instr;
   logic [15:0] m_imm;
   logic        m_has;
   logic [31:0] m_pc;
   logic [31:0] m_pcn;
   logic        m_valid;

   fetch_stage #(.IMM_FLAG_BIT(0), .NOP_WORD(16'h0000)) dut (
      .Clk(Clk), .Rst(Rst), .Stall(Stall), .Flush(Flush), .PC(PC),
      .InstrMemAddr(InstrMemAddr), .InstrMemData(InstrMemData), .NextPC(NextPC),
      .IFID_Instr(IFID_Instr), .IFID_Imm(IFID_Imm), .IFID_HasImm(IFID_HasImm),
      .IFID_PC(IFID_PC), .IFID_PCNext(IFID_PCNext), .IFID_Valid(IFID_Valid)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Apply one instruction-level event to the model.
   task automatic model_edge(input logic r, input logic f, input logic s,
                             input logic [31:0] pc, input logic [15:0] d);
      if (r || f) begin
         m_waiting = 1'b0;
         m_instr = 16'h0000; m_imm = 16'h0000; m_has = 1'b0;
         m_pc = 32'd0; m_pcn = 32'd0; m_valid = 1'b0;
         if (r) model_on = 1'b1;
      end else if (!s) begin
         if (m_waiting) begin
            m_instr = m_wait_op; m_imm = d; m_has = 1'b1;
            m_pc = m_wait_pc; m_pcn = pc + 32'd1; m_valid = 1'b1;
            m_waiting = 1'b0;
         end else if (d[0]) begin
            m_waiting = 1'b1; m_wait_op = d; m_wait_pc = pc;
            m_valid = 1'b0;
         end else begin
            m_instr = d; m_imm = 16'h0000; m_has = 1'b0;
            m_pc = pc; m_pcn = pc + 32'd1; m_valid = 1'b1;
         end
      end
   endtask

   // One clock: drive inputs, check the combinational outputs, clock the edge,
   // and advance the model.
   task automatic step(input logic r, input logic f, input logic s,
                       input logic [31:0] pc, input logic [15:0] d);
      @(negedge Clk);
      #1;
      Rst = r; Flush = f; Stall = s; PC = pc; InstrMemData = d;
      #1;
      chk("imem_addr", InstrMemAddr, pc);
      chk("next_pc", NextPC, (s && !f && !r) ? pc : pc + 32'd1);
      @(posedge Clk);
      model_edge(r, f, s, pc, d);
      #1;
   endtask

   // Compare the registered IF/ID outputs against the model every cycle.
   always @(negedge Clk) begin
      if (model_on) begin
         chk("ifid_instr", {16'd0, IFID_Instr}, {16'd0, m_instr});
         chk("ifid_imm", {16'd0, IFID_Imm}, {16'd0, m_imm});
         chk("ifid_has_imm", {31'd0, IFID_HasImm}, {31'd0, m_has});
         chk("ifid_pc", IFID_PC, m_pc);
         chk("ifid_pc_next", IFID_PCNext, m_pcn);
         chk("ifid_valid", {31'd0, IFID_Valid}, {31'd0, m_valid});
      end
   end

   initial begin
      Rst = 1'b1; Stall = 1'b0; Flush = 1'b0; PC = 32'd0; InstrMemData = 16'h0000;

      // Reset.
      step(1'b1, 1'b0, 1'b0, 32'd32, 16'h1234);
      chk("rst_valid", {31'd0, IFID_Valid}, 32'd0);
      chk("rst_instr", {16'd0, IFID_Instr}, 32'h0000);

      // One-word stream.
      step(1'b0, 1'b0, 1'b0, 32'd32, 16'h1230);
      chk("w1_instr", {16'd0, IFID_Instr}, 32'h1230);
      chk("w1_pc", IFID_PC, 32'd32);
      chk("w1_pcn", IFID_PCNext, 32'd33);
      chk("w1_valid", {31'd0, IFID_Valid}, 32'd1);
      step(1'b0, 1'b0, 1'b0, 32'd33, 16'h4560);
      chk("w2_instr", {16'd0, IFID_Instr}, 32'h4560);
      chk("w2_pcn", IFID_PCNext, 32'd34);

      // Two-word instruction.
      step(1'b0, 1'b0, 1'b0, 32'd40, 16'h8001);
      chk("tw_bubble", {31'd0, IFID_Valid}, 32'd0);
      step(1'b0, 1'b0, 1'b0, 32'd41, 16'hBEEF);
      chk("tw_instr", {16'd0, IFID_Instr}, 32'h8001);
      chk("tw_imm", {16'd0, IFID_Imm}, 32'hBEEF);
      chk("tw_has", {31'd0, IFID_HasImm}, 32'd1);
      chk("tw_pc", IFID_PC, 32'd40);
      chk("tw_pcn", IFID_PCNext, 32'd42);

      // Stall while waiting for the immediate.
      step(1'b0, 1'b0, 1'b0, 32'd40, 16'h8001);
      step(1'b0, 1'b0, 1'b1, 32'd41, 16'hBEEF);
      chk("st_nextpc", NextPC, 32'd41);
      chk("st_valid", {31'd0, IFID_Valid}, 32'd0);
      step(1'b0, 1'b0, 1'b1, 32'd41, 16'hBEEF);
      chk("st_valid2", {31'd0, IFID_Valid}, 32'd0);
      step(1'b0, 1'b0, 1'b0, 32'd41, 16'hBEEF);
      chk("st_instr", {16'd0, IFID_Instr}, 32'h8001);
      chk("st_imm", {16'd0, IFID_Imm}, 32'hBEEF);
      chk("st_pc", IFID_PC, 32'd40);

      // Flush and stall together while waiting for the immediate.
      step(1'b0, 1'b0, 1'b0, 32'd40, 16'h8001);
      step(1'b0, 1'b1, 1'b1, 32'd41, 16'hBEEF);
      chk("fl_valid", {31'd0, IFID_Valid}, 32'd0);
      chk("fl_instr", {16'd0, IFID_Instr}, 32'h0000);
      step(1'b0, 1'b0, 1'b0, 32'd0, 16'h2220);
      chk("fl_instr2", {16'd0, IFID_Instr}, 32'h2220);
      chk("fl_has", {31'd0, IFID_HasImm}, 32'd0);
      chk("fl_pc", IFID_PC, 32'd0);
      chk("fl_valid2", {31'd0, IFID_Valid}, 32'd1);

      // PC wrap.
      step(1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 16'h7770);
      chk("wr_pcn", IFID_PCNext, 32'd0);
      chk("wr_pc", IFID_PC, 32'hFFFFFFFF);

      // Reset mid-immediate with stall. BEEF must then be decoded as an opcode.
      step(1'b0, 1'b0, 1'b0, 32'd40, 16'h8001);
      step(1'b1, 1'b0, 1'b1, 32'd41, 16'hBEEF);
      chk("rm_valid", {31'd0, IFID_Valid}, 32'd0);
      step(1'b0, 1'b0, 1'b0, 32'd41, 16'hBEEF);
      chk("rm_bubble", {31'd0, IFID_Valid}, 32'd0);
      step(1'b0, 1'b0, 1'b0, 32'd42, 16'h1110);
      chk("rm_instr", {16'd0, IFID_Instr}, 32'hBEEF);
      chk("rm_imm", {16'd0, IFID_Imm}, 32'h1110);
      chk("rm_pc", IFID_PC, 32'd41);

      // Mixed traffic, checked against the model only.
      for (int i = 0; i < 300; i++) begin
         step(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 11) == 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 4) == 0) ? 1'b1 : 1'b0,
              $urandom, 16'($urandom));
      end

      @(negedge Clk);
      #2;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
